// File: rtl/dotbox_pkg.sv
// Shared types and constants for the dotbox scheduler slice.
package dotbox_pkg;

    localparam int LANES  = 8;
    localparam int LANE_W = 16;
    localparam int ACC_W  = 32;

    typedef logic signed [LANES-1:0][LANE_W-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/dotbox_rr_sched_arb.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/dotbox_rr_sched.sv
// Shares one dotbox among NUM_REQ requesters: round-robin accept, start pulse,
// wait for done or timeout, then a one-cycle response to the granted requester.
module dotbox_rr_sched
    import dotbox_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  vec_t [NUM_REQ-1:0]            req_x,
    input  vec_t [NUM_REQ-1:0]            req_y,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic signed [ACC_W-1:0]       rsp_dat,
    output logic signed [LANE_W-1:0]      rsp_dat16,
    output logic                          rsp_err,
    output vec_t                          db_x,
    output vec_t                          db_y,
    output logic                          db_start,
    input  logic signed [ACC_W-1:0]       db_dat,
    input  logic signed [LANE_W-1:0]      db_dat16,
    input  logic                          db_xfc,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_t               r_state;
    logic [IDX_W-1:0]           r_ptr;
    logic [IDX_W-1:0]           r_grant_id;
    logic [15:0]                r_timer;
    vec_t                       r_db_x;
    vec_t                       r_db_y;
    logic                       r_db_start;
    logic [NUM_REQ-1:0]         r_rsp_valid;
    logic signed [ACC_W-1:0]    r_rsp_dat;
    logic signed [LANE_W-1:0]   r_rsp_dat16;
    logic                       r_rsp_err;

    logic [NUM_REQ-1:0]         w_gnt;
    logic [IDX_W-1:0]           w_idx;
    logic                       w_any;
    logic [NUM_REQ-1:0]         w_grant_oh;
    logic [IDX_W-1:0]           w_ptr_nxt;
    logic                       w_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_grant_oh = NUM_REQ'(1) << r_grant_id;
    assign w_ptr_nxt  = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
    // Timer starts at 0 in the first WAIT cycle; give up on the cycle it would reach TIMEOUT-1.
    assign w_timeout  = (32'(r_timer) + 32'd1) >= (32'(TIMEOUT) - 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_timer     <= '0;
            r_db_x      <= '0;
            r_db_y      <= '0;
            r_db_start  <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_dat   <= '0;
            r_rsp_dat16 <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_db_start  <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_db_x     <= req_x[w_idx];
                        r_db_y     <= req_y[w_idx];
                        r_grant_id <= w_idx;
                        r_db_start <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_timer <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (db_xfc) begin
                        r_rsp_dat   <= db_dat;
                        r_rsp_dat16 <= db_dat16;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= w_grant_oh;
                        r_state     <= RESP;
                    end else if (w_timeout) begin
                        r_rsp_dat   <= '0;
                        r_rsp_dat16 <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= w_grant_oh;
                        r_state     <= RESP;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                RESP: begin
                    r_ptr   <= w_ptr_nxt;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE && !reset) ? w_gnt : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_dat16 = r_rsp_dat16;
    assign rsp_err   = r_rsp_err;
    assign db_x      = r_db_x;
    assign db_y      = r_db_y;
    assign db_start  = r_db_start;
    assign busy      = (r_state != IDLE);
    assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_dotbox_rr_sched.sv
// Directed bench for dotbox_rr_sched with a behavioural dotbox stub of programmable latency.
module tb_dotbox_rr_sched;
    import dotbox_pkg::*;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_ready;
    vec_t [NR-1:0] req_x = '0;
    vec_t [NR-1:0] req_y = '0;
    logic [NR-1:0] rsp_valid;
    logic [31:0]   rsp_dat;
    logic [15:0]   rsp_dat16;
    logic          rsp_err;
    vec_t          db_x;
    vec_t          db_y;
    logic          db_start;
    logic          db_xfc;
    logic          busy;
    logic [1:0]    grant_id;

    logic [31:0]   stub_dat = '0;
    logic [15:0]   stub_dat16 = '0;
    logic          stub_xfc = 1'b0;
    logic          force_xfc = 1'b0;
    logic          stub_never = 1'b0;
    int            stub_lat = 3;
    int            stub_cnt = 0;

    int checks = 0;
    int errors = 0;
    int n, s;

    assign db_xfc = stub_xfc | force_xfc;

    dotbox_rr_sched #(
        .NUM_REQ (NR),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_dat16 (rsp_dat16),
        .rsp_err   (rsp_err),
        .db_x      (db_x),
        .db_y      (db_y),
        .db_start  (db_start),
        .db_dat    (stub_dat),
        .db_dat16  (stub_dat16),
        .db_xfc    (db_xfc),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial forever #5 clk = ~clk;

    // Dotbox stand-in: xfc pulses stub_lat cycles after the start cycle.
    always @(negedge clk) begin
        int acc;
        stub_xfc = 1'b0;
        if (reset) begin
            stub_cnt = 0;
        end else if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) stub_xfc = 1'b1;
        end
        if (db_start && !stub_never && !reset) begin
            acc = 0;
            for (int l = 0; l < LANES; l++)
                acc += int'($signed(db_x[l])) * int'($signed(db_y[l]));
            stub_dat   = acc;
            stub_dat16 = acc[15:0];
            stub_cnt   = stub_lat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(output int cyc, output int starts);
        cyc = 0;
        starts = 0;
        while (rsp_valid == '0 && cyc < 60) begin
            tick();
            cyc++;
            if (db_start) starts++;
        end
    endtask

    task automatic wait_start();
        int c;
        c = 0;
        while (!db_start && c < 40) begin
            tick();
            c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_start", db_start, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_dat", rsp_dat, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_dbx", unsigned'(db_x), 0);

        // Single request: X = 1, Y = 1..8 gives 36.
        for (int l = 0; l < LANES; l++) begin
            req_x[0][l] = 16'd1;
            req_y[0][l] = 16'(l + 1);
        end
        reset = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        chk("t1_start", db_start, 1);
        chk("t1_gid", grant_id, 0);
        chk("t1_busy", busy, 1);
        chk("t1_dbx", unsigned'(db_x), unsigned'(req_x[0]));
        chk("t1_dby", unsigned'(db_y), unsigned'(req_y[0]));
        wait_rsp(n, s);
        chk("t1_lat", n, 4);
        chk("t1_starts", s, 0);
        chk("t1_rspv", rsp_valid, 4'b0001);
        chk("t1_dat", rsp_dat, 32'h0000_0024);
        chk("t1_dat16", rsp_dat16, 16'h0024);
        chk("t1_err", rsp_err, 0);
        chk("t1_dbx_hold", unsigned'(db_x), unsigned'(req_x[0]));
        tick();
        chk("t1_rspv_off", rsp_valid, 0);
        chk("t1_dat_hold", rsp_dat, 32'h0000_0024);
        chk("t1_idle", busy, 0);

        // Requests 0 and 2 together: 8*2*3 = 48, and -(1+4+...+64) = -204.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            req_x[0][l] = 16'd2;
            req_y[0][l] = 16'd3;
            req_x[2][l] = 16'(-(l + 1));
            req_y[2][l] = 16'(l + 1);
        end
        req_valid = 4'b0101;
        #1;
        chk("t2_ready0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0100;
        chk("t2_gid0", grant_id, 0);
        wait_rsp(n, s);
        chk("t2_starts0", s, 0);
        chk("t2_rspv0", rsp_valid, 4'b0001);
        chk("t2_dat0", rsp_dat, 32'h0000_0030);
        tick();
        chk("t2_ready2", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        chk("t2_gid2", grant_id, 2);
        chk("t2_dbx2", unsigned'(db_x), unsigned'(req_x[2]));
        wait_rsp(n, s);
        chk("t2_starts2", s, 0);
        chk("t2_rspv2", rsp_valid, 4'b0100);
        chk("t2_dat2", rsp_dat, 32'hFFFF_FF34);
        chk("t2_dat16_2", rsp_dat16, 16'hFF34);
        tick();

        // Fairness: all four held valid, requester i yields 8*(i+1).
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NR; i++)
            for (int l = 0; l < LANES; l++) begin
                req_x[i][l] = 16'(i + 1);
                req_y[i][l] = 16'd1;
            end
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            wait_start();
            chk("fair_start", db_start, 1);
            chk("fair_gid", grant_id, k % 4);
            wait_rsp(n, s);
            chk("fair_rspv", rsp_valid, 4'b0001 << (k % 4));
            chk("fair_dat", rsp_dat, 8 * (k % 4 + 1));
        end
        req_valid = '0;
        tick();

        // Timeout: no xfc, response 16 cycles after start with error.
        stub_never = 1'b1;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        chk("to_start", db_start, 1);
        chk("to_gid", grant_id, 1);
        wait_rsp(n, s);
        chk("to_lat", n, 16);
        chk("to_rspv", rsp_valid, 4'b0010);
        chk("to_err", rsp_err, 1);
        chk("to_dat", rsp_dat, 0);
        chk("to_dat16", rsp_dat16, 0);
        tick();
        stub_never = 1'b0;
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        chk("after_to_gid", grant_id, 3);
        wait_rsp(n, s);
        chk("after_to_rspv", rsp_valid, 4'b1000);
        chk("after_to_dat", rsp_dat, 32'h0000_0020);
        chk("after_to_err", rsp_err, 0);
        tick();

        // xfc on the timeout cycle wins.
        stub_lat = 15;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        wait_rsp(n, s);
        chk("co_lat", n, 16);
        chk("co_rspv", rsp_valid, 4'b0001);
        chk("co_err", rsp_err, 0);
        chk("co_dat", rsp_dat, 32'h0000_0008);
        tick();
        stub_lat = 3;

        // Stray xfc while idle.
        force_xfc = 1'b1;
        tick();
        force_xfc = 1'b0;
        chk("stray_rspv0", rsp_valid, 0);
        chk("stray_busy0", busy, 0);
        tick();
        chk("stray_rspv1", rsp_valid, 0);
        chk("stray_busy1", busy, 0);

        // Reset while waiting.
        stub_never = 1'b1;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        chk("mr_gid", grant_id, 2);
        repeat (3) tick();
        chk("mr_busy_pre", busy, 1);
        reset = 1'b1;
        tick();
        chk("mr_busy", busy, 0);
        chk("mr_rspv", rsp_valid, 0);
        chk("mr_start", db_start, 0);
        chk("mr_gid0", grant_id, 0);
        chk("mr_dbx", unsigned'(db_x), 0);
        chk("mr_dat", rsp_dat, 0);
        chk("mr_err", rsp_err, 0);
        chk("mr_ready", req_ready, 0);
        reset = 1'b0;
        stub_never = 1'b0;
        tick();
        chk("mr_rspv_after", rsp_valid, 0);
        req_valid = 4'b0011;
        #1;
        chk("mr_ready_after", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        chk("mr_gid_after", grant_id, 0);
        wait_rsp(n, s);
        chk("mr_rspv_new", rsp_valid, 4'b0001);
        chk("mr_dat_new", rsp_dat, 32'h0000_0008);
        chk("mr_err_new", rsp_err, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
